maj_seq_eval: RTL and testbench
===============================

Name: maj_seq_eval

Overview:
- Sequential evaluator for 7-input majority-gate networks.
- A single shared 3-input majority unit (with per-operand complement) is time-multiplexed across a programmable node list: one node per cycle.
- Replaces per-function combinational majority netlists with one reprogrammable block.
- Sits between the input-vector source (valid/ready) and the classification result sink (valid/ready).

Parameters:
- MAX_NODES, 8, node slots in program memory and node register file (1..16).
- SEL_W, derived localparam = clog2(8+MAX_NODES), operand select width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cfg_we  input  1  program write strobe
- cfg_addr  input  clog2(MAX_NODES)  node slot to write
- cfg_data  input  3*(SEL_W+1)  node word {opC, opB, opA}; each operand = {inv, sel}
- cfg_last  input  clog2(MAX_NODES)  last node index, latched with any accepted cfg_we
- cfg_out_inv  input  1  output complement, latched with any accepted cfg_we
- cfg_err  output  1  one-cycle pulse when cfg_we is dropped
- in_valid  input  1  input vector valid
- in_ready  output  1  block can accept a vector
- x  input  7  input vector; x[0]=x0 … x[6]=x6
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out  output  1  function value

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Operand decode:
  - sel 0..6 -> x latch bit sel.
  - sel 7 -> constant 0.
  - sel 8+j -> node register j.
  - sel 8+j with j >= MAX_NODES -> 0.
  - Operand value XOR inv.
  - Node value = MAJ(a,b,c) = ab|ac|bc.
- FSM states IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x, clear node register file, idx=0, go EVAL.
- EVAL:
  - Each cycle compute node idx from the current register file and write it to node[idx].
  - If idx==last_q, go DONE; else idx+1.
  - A reference to node j >= idx reads the cleared value 0; this is defined behaviour.
- DONE:
  - out_valid=1, out = node[last_q] XOR out_inv_q, both held stable until out_ready.
  - out_valid & out_ready -> IDLE.
  - No new vector is accepted in the handshake cycle.
- Latency: accept cycle T -> out_valid asserted at T+last_q+2.
- Throughput: one vector per last_q+3 cycles with out_ready tied 1.
- in_ready is 0 in EVAL and DONE.
- cfg_we:
  - Honoured only in IDLE: writes prog[cfg_addr], last_q<=cfg_last, out_inv_q<=cfg_out_inv.
  - In EVAL/DONE the write is dropped and cfg_err pulses for 1 cycle.
  - cfg_we and in_valid in the same IDLE cycle: both take effect; the evaluation uses the new program word.
- cfg_last >= MAX_NODES (only possible if MAX_NODES is not a power of 2): clamp to MAX_NODES-1.
- Reset (any state, including mid-EVAL):
  - state=IDLE, out_valid=0, out=0, in_ready=1 the cycle after reset deasserts, cfg_err=0.
  - Program memory cleared to all-zero words (MAJ(x0,x0,x0)=x0); last_q=0; out_inv_q=0; node registers=0.
  - Any in-flight result is discarded.

Optional Feature:
- Macro MAJ_SEQ_NODE_DBG_EN.
- When defined: adds output port node_vec [MAX_NODES-1:0], a direct copy of the node register file, valid in DONE, updated each EVAL cycle.
- When undefined: port absent; no other behaviour change.

Test Plan:
- Reset then program 1 node {A=sel0, B=sel1, C=sel2, no inv}, last=0; x=7'b0000011 -> out_valid 2 cycles after accept, out=1; x=7'b0000001 -> out=0.
- Program 7 nodes:
  - n0=MAJ(x1,x2,x3), n1=MAJ(x4,x5,x6), n2=MAJ(x0,x2,x3), n3=MAJ(x0,x5,x6)
  - n4=MAJ(x1,n1,n2), n5=MAJ(x4,n0,n3), n6=MAJ(x0,n4,n5); last=6
  - Vectors and required out: x=7'h7F -> 1; x=7'h03 -> 0; x=7'h07 -> 1.
  - Each result arrives 8 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid/out stable, in_ready=0, second in_valid not accepted until the handshake.
- cfg_we asserted during EVAL -> cfg_err pulses once, program unchanged (rerun gives identical out).
- Complement: program n0 with opA inv=1 and cfg_out_inv=1; x=0 -> out = ~MAJ(1,0,0) = 1.
- Assert rst mid-EVAL -> next cycle out_valid=0, in_ready=1; evaluating x=7'h01 yields out=1 (default program, identity of x0).

Source files
------------

// File: rtl/maj_seq_eval.sv
// rtl/maj_seq_eval.sv - time-multiplexed 3-input majority network evaluator
// Optional node register debug port: define MAJ_SEQ_NODE_DBG_EN.
module maj_seq_eval #(
    parameter  int MAX_NODES = 8,
    localparam int SEL_W     = $clog2(8 + MAX_NODES),
    localparam int OP_W      = SEL_W + 1,
    localparam int AW        = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [3*OP_W-1:0]     cfg_data,
    input  logic [AW-1:0]         cfg_last,
    input  logic                  cfg_out_inv,
    output logic                  cfg_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            x,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef MAJ_SEQ_NODE_DBG_EN
    output logic [MAX_NODES-1:0]  node_vec,
`endif
    output logic                  out
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [6:0]            x_q;
    logic [MAX_NODES-1:0]  node_q;
    logic [3*OP_W-1:0]     prog_q [MAX_NODES];
    logic [AW-1:0]         idx_q;
    logic [AW-1:0]         last_q;
    logic                  out_inv_q;
    logic                  cfg_err_q;
    logic [3*OP_W-1:0]     cur_word;
    logic                  op_a, op_b, op_c;
    logic                  node_val;
    logic                  cfg_ok;

    // Operand select: 0..6 input bits, 7 constant zero, 8+j node j (0 if j out of range)
    function automatic logic op_val(input logic [OP_W-1:0] op,
                                    input logic [6:0] xv,
                                    input logic [MAX_NODES-1:0] nv);
        logic [SEL_W-1:0] sel;
        logic [SEL_W-1:0] j;
        logic             v;
        sel = op[SEL_W-1:0];
        j   = sel - SEL_W'(8);
        v   = 1'b0;
        if (sel < SEL_W'(7))
            v = xv[sel[2:0]];
        else if (sel >= SEL_W'(8) && 32'(j) < MAX_NODES)
            v = nv[j[AW-1:0]];
        return v ^ op[OP_W-1];
    endfunction

    always_comb begin
        cur_word = prog_q[idx_q];
        op_a     = op_val(cur_word[OP_W-1:0], x_q, node_q);
        op_b     = op_val(cur_word[2*OP_W-1:OP_W], x_q, node_q);
        op_c     = op_val(cur_word[3*OP_W-1:2*OP_W], x_q, node_q);
        node_val = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        cfg_ok   = cfg_we && (state_q == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EVAL;
            S_EVAL:  if (idx_q == last_q) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out       = (state_q == S_DONE) ? (node_q[last_q] ^ out_inv_q) : 1'b0;
        cfg_err   = cfg_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            node_q    <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            out_inv_q <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < MAX_NODES; i++)
                prog_q[i] <= '0;
        end else begin
            cfg_err_q <= cfg_we && (state_q != S_IDLE);
            if (cfg_ok) begin
                if (32'(cfg_addr) < MAX_NODES)
                    prog_q[cfg_addr] <= cfg_data;
                if (32'(cfg_last) >= MAX_NODES)
                    last_q <= AW'(MAX_NODES - 1);
                else
                    last_q <= cfg_last;
                out_inv_q <= cfg_out_inv;
            end
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q    <= x;
                        node_q <= '0;
                        idx_q  <= '0;
                    end
                end
                S_EVAL: begin
                    node_q[idx_q] <= node_val;
                    if (idx_q != last_q)
                        idx_q <= idx_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MAJ_SEQ_NODE_DBG_EN
    assign node_vec = node_q;
`endif

endmodule

// File: tb/tb_maj_seq_eval.sv
// tb/tb_maj_seq_eval.sv - directed table-driven bench for maj_seq_eval
module tb_maj_seq_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic [2:0]  cfg_last;
    logic        cfg_out_inv;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  x;
    logic        out_valid;
    logic        out_ready;
    logic        out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] xv;
        logic       exp_out;
        int         exp_lat;
    } vec_t;

    vec_t tbl1 [2];
    vec_t tbl7 [5];

    maj_seq_eval #(.MAX_NODES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_out_inv(cfg_out_inv),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic ia, input logic [3:0] a,
                                       input logic ib, input logic [3:0] b,
                                       input logic ic, input logic [3:0] c);
        return {ic, c, ib, b, ia, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic prog(input logic [2:0] addr, input logic [14:0] word,
                        input logic [2:0] last, input logic inv);
        cfg_we      = 1'b1;
        cfg_addr    = addr;
        cfg_data    = word;
        cfg_last    = last;
        cfg_out_inv = inv;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic prog7();
        prog(3'd0, mk(0, 4'd1, 0, 4'd2,  0, 4'd3),  3'd6, 1'b0);
        prog(3'd1, mk(0, 4'd4, 0, 4'd5,  0, 4'd6),  3'd6, 1'b0);
        prog(3'd2, mk(0, 4'd0, 0, 4'd2,  0, 4'd3),  3'd6, 1'b0);
        prog(3'd3, mk(0, 4'd0, 0, 4'd5,  0, 4'd6),  3'd6, 1'b0);
        prog(3'd4, mk(0, 4'd1, 0, 4'd9,  0, 4'd10), 3'd6, 1'b0);
        prog(3'd5, mk(0, 4'd4, 0, 4'd8,  0, 4'd11), 3'd6, 1'b0);
        prog(3'd6, mk(0, 4'd0, 0, 4'd12, 0, 4'd13), 3'd6, 1'b0);
    endtask

    // Count cycles from the accept cycle until out_valid rises
    task automatic wait_result(input int start, output int n);
        n = start;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic run_vec(input string nm, input logic [6:0] xv,
                           input logic exp_out, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        x        = xv;
        tick();
        in_valid = 1'b0;
        wait_result(1, n);
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_out"}, int'(out), int'(exp_out));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        tbl1[0] = '{7'b0000011, 1'b1, 2};
        tbl1[1] = '{7'b0000001, 1'b0, 2};
        tbl7[0] = '{7'h7F, 1'b1, 8};
        tbl7[1] = '{7'h03, 1'b0, 8};
        tbl7[2] = '{7'h07, 1'b1, 8};
        tbl7[3] = '{7'h70, 1'b0, 8};
        tbl7[4] = '{7'h79, 1'b1, 8};

        cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_last = 0; cfg_out_inv = 0;
        in_valid = 0; x = 0; out_ready = 0;
        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_cfg_err",   int'(cfg_err),   0);
        chk("rst_out",       int'(out),       0);

        prog(3'd0, mk(0, 4'd0, 0, 4'd1, 0, 4'd2), 3'd0, 1'b0);
        for (int i = 0; i < 2; i++)
            run_vec($sformatf("one_node_%0d", i), tbl1[i].xv, tbl1[i].exp_out, tbl1[i].exp_lat);

        prog7();
        chk("prog_cfg_err", int'(cfg_err), 0);
        for (int i = 0; i < 5; i++)
            run_vec($sformatf("seven_node_%0d", i), tbl7[i].xv, tbl7[i].exp_out, tbl7[i].exp_lat);

        // Backpressure: result held, no second accept until handshake
        in_valid = 1'b1;
        x        = 7'h7F;
        tick();
        x        = 7'h03;
        wait_result(1, n);
        chk("bp_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid_%0d", i), int'(out_valid), 1);
            chk($sformatf("bp_out_%0d", i),   int'(out),       1);
            chk($sformatf("bp_ready_%0d", i), int'(in_ready),  0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp_post_valid", int'(out_valid), 0);
        chk("bp_post_ready", int'(in_ready),  1);
        run_vec("bp_next", 7'h03, 1'b0, 8);

        // Write during EVAL is dropped and flagged
        in_valid = 1'b1;
        x        = 7'h07;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = '0; cfg_last = 3'd0; cfg_out_inv = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("err_pulse", int'(cfg_err), 1);
        tick();
        chk("err_clear", int'(cfg_err), 0);
        wait_result(3, n);
        chk("err_lat", n, 8);
        chk("err_out", int'(out), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_vec("err_rerun", 7'h07, 1'b1, 8);

        // Operand and output complement
        prog(3'd0, mk(1, 4'd0, 0, 4'd1, 0, 4'd2), 3'd0, 1'b1);
        run_vec("inv_x0", 7'h00, 1'b1, 2);
        run_vec("inv_x7", 7'h07, 1'b0, 2);

        // Reset mid-EVAL discards the result and restores the default program
        prog7();
        in_valid = 1'b1;
        x        = 7'h7F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_in_ready",  int'(in_ready),  1);
        chk("mrst_cfg_err",   int'(cfg_err),   0);
        run_vec("mrst_default", 7'h01, 1'b1, 2);
        run_vec("mrst_default0", 7'h7E, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
